fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 64'h0; PC value loaded on reset.
REQ-002 Port: clk, input, 1, single clock, all state rising-edge.
REQ-003 Port: rst, input, 1, reset, asynchronous, active-high.
REQ-004 Port: stall, input, 1, hazard-unit stall; hold PC and IF/ID register.
REQ-005 Port: br_taken, input, 1, ID stage resolved a taken branch this cycle.
REQ-006 Port: br_sel, input, 2, target kind (br_sel_t): BR_IMM26, BR_IMM19, BR_REG.
REQ-007 Port: br_pc, input, 64, PC of the branch instruction in ID.
REQ-008 Port: br_imm26, input, 26, B/BL word offset, signed.
REQ-009 Port: br_imm19, input, 19, CBZ/B.cond word offset, signed.
REQ-010 Port: br_reg, input, 64, BR register target (byte address).
REQ-011 Port: imem_addr, output, 64, instruction memory address (= current PC).
REQ-012 Port: imem_rdata, input, 32, instruction word, combinational read of imem_addr.
REQ-013 Port: id_instr, output, 32, registered instruction to ID.
REQ-014 Port: id_pc, output, 64, registered PC of id_instr.
REQ-015 Port: id_valid, output, 1, id_instr is a real fetched instruction (0 = bubble).

Function
REQ-016 imem_addr SHALL equal the PC register combinationally; no other logic on that path.
REQ-017 Next-PC priority SHALL be: stall (hold) > br_taken (redirect) > sequential (PC+4).
REQ-018 Redirect target SHALL be: BR_IMM26 -> br_pc + (sext(br_imm26) << 2); BR_IMM19 -> br_pc + (sext(br_imm19) << 2); BR_REG -> br_reg unchanged.
REQ-019 All PC arithmetic SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.
REQ-020 Branches SHALL use one delay slot: the instruction fetched in the cycle br_taken is seen advances to ID normally; the target is fetched the next cycle.
REQ-021 When not stalled, each rising edge SHALL load id_instr <= imem_rdata, id_pc <= PC, id_valid <= 1.
REQ-022 When stall=1, PC, id_instr, id_pc, id_valid SHALL all hold; br_taken in the same cycle SHALL be ignored (ID holds, so the branch is re-presented).
REQ-023 Fetch-to-ID latency SHALL be exactly one cycle; redirect-to-target-fetch latency exactly one cycle.
REQ-024 br_sel encoding 2'b11 SHALL be treated as sequential (no redirect).
REQ-025 br_taken while id_valid=0 SHALL be ignored.

Reset
REQ-026 On rst assertion, asynchronously: PC <= RESET_PC, id_instr <= NOP (32'hD503201F), id_pc <= 0, id_valid <= 0.
REQ-027 First rising edge after rst deasserts SHALL fetch RESET_PC; id_valid goes 1 after that edge.
REQ-028 Reset mid-operation SHALL discard any pending redirect and stall state; no partial update.

Structure
REQ-029 cpu_pkg SHALL hold br_sel_t enum, NOP_INSTR constant and INSTR_W/ADDR_W widths.
REQ-030 One sub-module, branch_target (combinational: br_sel, br_pc, imms, br_reg -> 64-bit target), SHALL be instantiated.
REQ-031 PC register and IF/ID register SHALL live in fetch_stage; total RTL 120-400 lines.

Verification
REQ-032 Reset release, RESET_PC=0, memory word0=32'h8B020020 -> imem_addr=0, then 4, 8; id_instr=32'h8B020020, id_pc=0, id_valid=1 after first edge.
REQ-033 br_taken=1, BR_IMM26, br_pc=64'h10, br_imm26=26'h3FFFFFE (-2) while PC=64'h14 -> instr at 0x14 reaches ID, next imem_addr=64'h8.
REQ-034 BR_IMM19, br_pc=64'h100, br_imm19=19'h10 -> next imem_addr=64'h140; BR_REG br_reg=64'hDEAD_BEE0 -> next imem_addr=64'hDEAD_BEE0.
REQ-035 stall=1 for 3 cycles with br_taken=1 throughout -> PC, id_* frozen; after stall drops with br_taken=1, one redirect occurs.
REQ-036 PC=64'hFFFF_FFFF_FFFF_FFFC, no stall/branch -> next imem_addr=0.
REQ-037 rst pulsed asynchronously between edges mid-stream -> outputs immediately at reset values (id_valid=0, id_instr=NOP), PC=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch stage.
//   br_sel_t    : branch target kind presented by ID.
//   NOP_INSTR   : instruction word held in IF/ID while it carries a bubble.
//   INSTR_W/ADDR_W and immediate widths.
//   sext_words_*: sign-extend a word offset and scale it to a byte offset.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int IMM26_W = 26;
  localparam int IMM19_W = 19;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503_201F;

  typedef enum logic [1:0] {
    BR_IMM26 = 2'b00,
    BR_IMM19 = 2'b01,
    BR_REG   = 2'b10
  } br_sel_t;

  // Word offset (B/BL) -> signed 64-bit byte offset.
  function automatic logic [ADDR_W-1:0] sext_words_imm26(input logic [IMM26_W-1:0] imm);
    return {{(ADDR_W-IMM26_W-2){imm[IMM26_W-1]}}, imm, 2'b00};
  endfunction

  // Word offset (CBZ/B.cond) -> signed 64-bit byte offset.
  function automatic logic [ADDR_W-1:0] sext_words_imm19(input logic [IMM19_W-1:0] imm);
    return {{(ADDR_W-IMM19_W-2){imm[IMM19_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target.sv
// branch_target: combinational redirect-target computation.
//   br_sel    : target kind (br_sel_t encoding; 2'b11 is not a redirect)
//   br_pc     : PC of the branch instruction
//   br_imm26  : signed word offset for B/BL
//   br_imm19  : signed word offset for CBZ/B.cond
//   br_reg    : register target (byte address, used unchanged)
//   target    : 64-bit target, modulo 2^64
//   tgt_valid : 1 when br_sel names a real target kind
module branch_target
  import cpu_pkg::*;
(
  input  logic [1:0]         br_sel,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [IMM26_W-1:0] br_imm26,
  input  logic [IMM19_W-1:0] br_imm19,
  input  logic [ADDR_W-1:0]  br_reg,
  output logic [ADDR_W-1:0]  target,
  output logic               tgt_valid
);

  // Select and compute the target address for the requested branch kind.
  always_comb begin
    target    = br_pc;
    tgt_valid = 1'b0;
    case (br_sel)
      BR_IMM26: begin
        target    = br_pc + sext_words_imm26(br_imm26);
        tgt_valid = 1'b1;
      end
      BR_IMM19: begin
        target    = br_pc + sext_words_imm19(br_imm19);
        tgt_valid = 1'b1;
      end
      BR_REG: begin
        target    = br_reg;
        tgt_valid = 1'b1;
      end
      default: begin
        // Unused encoding: behaves as no branch at all.
        target    = br_pc;
        tgt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   stall         : hold PC and IF/ID (any branch this cycle is ignored)
//   br_taken      : ID resolved a taken branch (one delay slot)
//   br_sel        : target kind; br_pc/br_imm26/br_imm19/br_reg feed the target
//   imem_addr     : instruction memory address, wired straight from the PC flop
//   imem_rdata    : combinational instruction read of imem_addr
//   id_instr/id_pc/id_valid : IF/ID register contents (id_valid=0 is a bubble)
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [1:0]         br_sel,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [IMM26_W-1:0] br_imm26,
  input  logic [IMM19_W-1:0] br_imm19,
  input  logic [ADDR_W-1:0]  br_reg,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid
);

  logic [ADDR_W-1:0]  pc_q,       pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]  id_pc_q,    id_pc_d;
  logic               id_valid_q, id_valid_d;

  logic [ADDR_W-1:0]  target_s;
  logic               tgt_valid_s;
  logic               redirect_s;

  branch_target u_branch_target (
    .br_sel    (br_sel),
    .br_pc     (br_pc),
    .br_imm26  (br_imm26),
    .br_imm19  (br_imm19),
    .br_reg    (br_reg),
    .target    (target_s),
    .tgt_valid (tgt_valid_s)
  );

  // A branch can only come from a real instruction sitting in ID.
  assign redirect_s = br_taken & id_valid_q & tgt_valid_s;

  // Next-state for PC and IF/ID: stall holds everything, else fetch advances.
  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (stall) begin
      pc_d       = pc_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
    end else begin
      // The word fetched this cycle always moves to ID (delay slot).
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      if (redirect_s) begin
        pc_d = target_s;
      end else begin
        pc_d = pc_q + 64'd4;
      end
    end
  end

  // PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 64'h0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [1:0]  br_sel;
  logic [63:0] br_pc;
  logic [25:0] br_imm26;
  logic [18:0] br_imm19;
  logic [63:0] br_reg;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_valid;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'hD503_201F;

  // Instruction memory: word 0 is the reference ADD, others address-derived.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B02_0020;
    else            return a[31:0] ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_sel     (br_sel),
    .br_pc      (br_pc),
    .br_imm26   (br_imm26),
    .br_imm19   (br_imm19),
    .br_reg     (br_reg),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_branch();
    br_taken = 1'b0;
    br_sel   = 2'b00;
    br_pc    = 64'h0;
    br_imm26 = 26'h0;
    br_imm19 = 19'h0;
    br_reg   = 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    no_branch();
    step();
    step();
    n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", imem_addr, 64'h0); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
    n_cmp++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL reset_idpc: got %h want 0", id_pc); end
  endtask

  task automatic test_sequential();
    // Branch presented while ID holds a bubble must be ignored.
    rst = 1'b0;
    br_taken = 1'b1; br_sel = 2'b10; br_reg = 64'h40;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'h4) begin n_err++; $display("FAIL seq1_pc: got %h want %h", imem_addr, 64'h4); end
    n_cmp++; if (id_instr !== 32'h8B02_0020) begin n_err++; $display("FAIL seq1_instr: got %h want %h", id_instr, 32'h8B02_0020); end
    n_cmp++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL seq1_idpc: got %h want 0", id_pc); end
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL seq1_valid: got %b want 1", id_valid); end
    step();
    n_cmp++; if (imem_addr !== 64'h8) begin n_err++; $display("FAIL seq2_pc: got %h want %h", imem_addr, 64'h8); end
    n_cmp++; if (id_pc !== 64'h4) begin n_err++; $display("FAIL seq2_idpc: got %h want %h", id_pc, 64'h4); end
    n_cmp++; if (id_instr !== 32'h1234_567C) begin n_err++; $display("FAIL seq2_instr: got %h want %h", id_instr, 32'h1234_567C); end
  endtask

  task automatic test_imm26();
    br_taken = 1'b1; br_sel = 2'b10; br_reg = 64'h14;
    step();
    n_cmp++; if (imem_addr !== 64'h14) begin n_err++; $display("FAIL jmp14_pc: got %h want %h", imem_addr, 64'h14); end
    br_sel = 2'b00; br_pc = 64'h10; br_imm26 = 26'h3FF_FFFE;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'h8) begin n_err++; $display("FAIL imm26_pc: got %h want %h", imem_addr, 64'h8); end
    n_cmp++; if (id_pc !== 64'h14) begin n_err++; $display("FAIL imm26_slot_pc: got %h want %h", id_pc, 64'h14); end
    n_cmp++; if (id_instr !== 32'h1234_566C) begin n_err++; $display("FAIL imm26_slot_instr: got %h want %h", id_instr, 32'h1234_566C); end
  endtask

  task automatic test_imm19();
    br_taken = 1'b1; br_sel = 2'b01; br_pc = 64'h100; br_imm19 = 19'h10;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'h140) begin n_err++; $display("FAIL imm19_pc: got %h want %h", imem_addr, 64'h140); end
    n_cmp++; if (id_pc !== 64'h8) begin n_err++; $display("FAIL imm19_slot_pc: got %h want %h", id_pc, 64'h8); end
  endtask

  task automatic test_breg();
    br_taken = 1'b1; br_sel = 2'b10; br_reg = 64'hDEAD_BEE0;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'hDEAD_BEE0) begin n_err++; $display("FAIL breg_pc: got %h want %h", imem_addr, 64'hDEAD_BEE0); end
    n_cmp++; if (id_pc !== 64'h140) begin n_err++; $display("FAIL breg_slot_pc: got %h want %h", id_pc, 64'h140); end
  endtask

  task automatic test_sel11();
    br_taken = 1'b1; br_sel = 2'b11; br_pc = 64'h100; br_reg = 64'h700;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'hDEAD_BEE4) begin n_err++; $display("FAIL sel11_pc: got %h want %h", imem_addr, 64'hDEAD_BEE4); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    br_taken = 1'b1; br_sel = 2'b10; br_reg = 64'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (imem_addr !== 64'hDEAD_BEE4) begin n_err++; $display("FAIL stall%0d_pc: got %h want %h", i, imem_addr, 64'hDEAD_BEE4); end
      n_cmp++; if (id_pc !== 64'hDEAD_BEE0) begin n_err++; $display("FAIL stall%0d_idpc: got %h want %h", i, id_pc, 64'hDEAD_BEE0); end
      n_cmp++; if (id_instr !== (32'hDEAD_BEE0 ^ 32'h1234_5678)) begin n_err++; $display("FAIL stall%0d_instr: got %h want %h", i, id_instr, 32'hDEAD_BEE0 ^ 32'h1234_5678); end
      n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL stall%0d_valid: got %b want 1", i, id_valid); end
    end
    stall = 1'b0;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'h500) begin n_err++; $display("FAIL unstall_redirect_pc: got %h want %h", imem_addr, 64'h500); end
    n_cmp++; if (id_pc !== 64'hDEAD_BEE4) begin n_err++; $display("FAIL unstall_idpc: got %h want %h", id_pc, 64'hDEAD_BEE4); end
    step();
    n_cmp++; if (imem_addr !== 64'h504) begin n_err++; $display("FAIL unstall_seq_pc: got %h want %h", imem_addr, 64'h504); end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_sel = 2'b10; br_reg = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_pre_pc: got %h want %h", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC); end
    step();
    n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
    n_cmp++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_idpc: got %h want %h", id_pc, 64'hFFFF_FFFF_FFFF_FFFC); end
    n_cmp++; if (id_instr !== 32'hEDCB_A984) begin n_err++; $display("FAIL wrap_instr: got %h want %h", id_instr, 32'hEDCB_A984); end
  endtask

  task automatic test_async_reset();
    step();
    n_cmp++; if (imem_addr !== 64'h4) begin n_err++; $display("FAIL prerst_pc: got %h want %h", imem_addr, 64'h4); end
    br_taken = 1'b1; br_sel = 2'b10; br_reg = 64'h900;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL arst_instr: got %h want %h", id_instr, NOP); end
    n_cmp++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL arst_idpc: got %h want 0", id_pc); end
    n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL arst_pc: got %h want 0", imem_addr); end
    #1;
    rst = 1'b0;
    step();
    no_branch();
    n_cmp++; if (imem_addr !== 64'h4) begin n_err++; $display("FAIL postrst_pc: got %h want %h", imem_addr, 64'h4); end
    n_cmp++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL postrst_idpc: got %h want 0", id_pc); end
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL postrst_valid: got %b want 1", id_valid); end
    n_cmp++; if (id_instr !== 32'h8B02_0020) begin n_err++; $display("FAIL postrst_instr: got %h want %h", id_instr, 32'h8B02_0020); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_imm26();
    test_imm19();
    test_breg();
    test_sel11();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
